// File: rtl/mul_ctrl_pkg.sv
// rtl/mul_ctrl_pkg.sv - shared encodings and helpers for the HI/LO multiply sequencer
//
// Purpose : op encodings, sequencer state enum, HI/LO commit modes and op
//           classification helpers used by mul_hilo_ctrl and mul_hilo_acc.
// Ports   : none (package).
// Config  : MUL_ACCUM_EN - when defined, MADD/MADDU/MSUB/MSUBU are legal ops.

package mul_ctrl_pkg;

  localparam int HILO_W = 64;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MADD  = 3'b010;
  localparam logic [2:0] OP_MADDU = 3'b011;
  localparam logic [2:0] OP_MSUB  = 3'b100;
  localparam logic [2:0] OP_MSUBU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2
  } state_t;

  // How a commit updates {hi,lo}: overwrite, or accumulate +/- operand.
  typedef enum logic [1:0] {
    HL_LOAD = 2'd0,
    HL_ADD  = 2'd1,
    HL_SUB  = 2'd2
  } hl_mode_t;

  function automatic logic op_is_legal(input logic [2:0] op);
`ifdef MUL_ACCUM_EN
    return (op <= OP_MSUBU);
`else
    return (op == OP_MULT) || (op == OP_MULTU);
`endif
  endfunction

  // Only meaningful for legal ops: anything above MULTU accumulates.
  function automatic logic op_is_accum(input logic [2:0] op);
    return (op[2] | op[1]);
  endfunction

  function automatic logic op_is_sub(input logic [2:0] op);
    return (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

endpackage

// File: rtl/mul_hilo_acc.sv
// rtl/mul_hilo_acc.sv - HI/LO register pair with MT writes and 64-bit accumulate
//
// Purpose : holds {hi,lo}; a commit overwrites, adds or subtracts a 64-bit
//           operand (mod 2^64); otherwise MTHI/MTLO write the halves.
// Ports   : mul_clk, reset (sync, active-high)
//           mthi_we, mtlo_we, mt_data[31:0]  - MT writes (caller gates to idle)
//           commit, mode, operand[63:0]       - product / accumulate update
//           hi[31:0], lo[31:0]                - register outputs
// Config  : MUL_ACCUM_EN (add/sub modes only exercised when defined).

module mul_hilo_acc
  import mul_ctrl_pkg::*;
(
  input  logic              mul_clk,
  input  logic              reset,
  input  logic              mthi_we,
  input  logic              mtlo_we,
  input  logic [31:0]       mt_data,
  input  logic              commit,
  input  hl_mode_t          mode,
  input  logic [HILO_W-1:0] operand,
  output logic [31:0]       hi,
  output logic [31:0]       lo
);

  logic [HILO_W-1:0] hilo_q;
  logic [HILO_W-1:0] hilo_d;

  always_comb begin
    hilo_d = hilo_q;
    if (commit) begin
      case (mode)
        HL_ADD:  hilo_d = hilo_q + operand;
        HL_SUB:  hilo_d = hilo_q - operand;
        default: hilo_d = operand;
      endcase
    end else begin
      if (mthi_we) hilo_d[63:32] = mt_data;
      if (mtlo_we) hilo_d[31:0]  = mt_data;
    end
  end

  always_ff @(posedge mul_clk) begin
    if (reset) hilo_q <= '0;
    else       hilo_q <= hilo_d;
  end

  assign hi = hilo_q[63:32];
  assign lo = hilo_q[31:0];

endmodule

// File: rtl/mul_hilo_ctrl.sv
// rtl/mul_hilo_ctrl.sv - EX-stage sequencer for the external pipelined multiplier
//
// Purpose : accepts MULT/MULTU (and MADD*/MSUB* with MUL_ACCUM_EN) through
//           req_valid/req_ready, holds operands for the multiplier, waits out
//           MUL_LATENCY, commits the product to HI/LO and pulses done.
//           Services MTHI/MTLO in idle and kills the in-flight op on flush.
// Ports   : mul_clk, reset (sync, active-high)
//           req_valid/req_ready/req_op[2:0]/req_x/req_y - op handshake
//           flush                                        - kill in-flight op
//           mthi_we/mtlo_we/mt_data                      - HI/LO moves
//           mul_x/mul_y/mul_signed/mul_resetn/mul_result - multiplier link
//           hi/lo, busy, done                            - results and status
// Config  : MUL_ACCUM_EN - adds ACC state, prod register, accumulate ops.

module mul_hilo_ctrl
  import mul_ctrl_pkg::*;
#(
  parameter int MUL_LATENCY = 1
) (
  input  logic        mul_clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_x,
  input  logic [31:0] req_y,
  input  logic        flush,
  input  logic        mthi_we,
  input  logic        mtlo_we,
  input  logic [31:0] mt_data,
  output logic [31:0] mul_x,
  output logic [31:0] mul_y,
  output logic        mul_signed,
  output logic        mul_resetn,
  input  logic [63:0] mul_result,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  localparam int CNT_W = (MUL_LATENCY > 0) ? $clog2(MUL_LATENCY + 1) : 1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              accept;
  logic              hl_commit;
  hl_mode_t          hl_mode;
  logic [HILO_W-1:0] hl_operand;
`ifdef MUL_ACCUM_EN
  logic [2:0]        op_q;
  logic [HILO_W-1:0] prod_q;
  logic              prod_load;
`endif

  assign req_ready  = (state_q == IDLE);
  assign busy       = ~req_ready;
  assign done       = done_q;
  assign mul_resetn = ~reset;
  // Illegal ops still complete the handshake; they simply never leave IDLE.
  assign accept     = req_valid & req_ready & ~flush;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    hl_commit  = 1'b0;
    hl_mode    = HL_LOAD;
    hl_operand = mul_result;
`ifdef MUL_ACCUM_EN
    prod_load  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (accept && op_is_legal(req_op)) begin
          state_d = MUL;
          cnt_d   = CNT_W'(MUL_LATENCY);
        end
      end
      MUL: begin
        // Flush takes priority even over a commit in the final MUL cycle.
        if (flush) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
`ifdef MUL_ACCUM_EN
          if (op_is_accum(op_q)) begin
            prod_load = 1'b1;
            state_d   = ACC;
          end else
`endif
          begin
            hl_commit = 1'b1;
            done_d    = 1'b1;
            state_d   = IDLE;
          end
        end
      end
`ifdef MUL_ACCUM_EN
      ACC: begin
        state_d = IDLE;
        if (!flush) begin
          hl_commit  = 1'b1;
          done_d     = 1'b1;
          hl_operand = prod_q;
          hl_mode    = HL_ADD;
          if (op_is_sub(op_q)) hl_mode = HL_SUB;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge mul_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      mul_x      <= '0;
      mul_y      <= '0;
      mul_signed <= 1'b0;
`ifdef MUL_ACCUM_EN
      op_q       <= '0;
      prod_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      if (accept) begin
        mul_x      <= req_x;
        mul_y      <= req_y;
        mul_signed <= ~req_op[0];
`ifdef MUL_ACCUM_EN
        op_q       <= req_op;
`endif
      end
`ifdef MUL_ACCUM_EN
      if (prod_load) prod_q <= mul_result;
`endif
    end
  end

  // MT moves are only honoured while idle so they cannot race a commit.
  mul_hilo_acc u_hilo (
    .mul_clk (mul_clk),
    .reset   (reset),
    .mthi_we (mthi_we & req_ready),
    .mtlo_we (mtlo_we & req_ready),
    .mt_data (mt_data),
    .commit  (hl_commit),
    .mode    (hl_mode),
    .operand (hl_operand),
    .hi      (hi),
    .lo      (lo)
  );

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// tb/tb_mul_hilo_ctrl.sv - directed self-checking bench for mul_hilo_ctrl

module tb_mul_hilo_ctrl;
  import mul_ctrl_pkg::*;

  logic        mul_clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_x;
  logic [31:0] req_y;
  logic        flush;
  logic        mthi_we;
  logic        mtlo_we;
  logic [31:0] mt_data;
  logic [31:0] mul_x;
  logic [31:0] mul_y;
  logic        mul_signed;
  logic        mul_resetn;
  logic [63:0] mul_result;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  mul_hilo_ctrl #(.MUL_LATENCY(1)) dut (
    .mul_clk    (mul_clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_x      (req_x),
    .req_y      (req_y),
    .flush      (flush),
    .mthi_we    (mthi_we),
    .mtlo_we    (mtlo_we),
    .mt_data    (mt_data),
    .mul_x      (mul_x),
    .mul_y      (mul_y),
    .mul_signed (mul_signed),
    .mul_resetn (mul_resetn),
    .mul_result (mul_result),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done)
  );

  initial mul_clk = 1'b0;
  always #5 mul_clk = ~mul_clk;

  // One-cycle multiplier model: samples x/y at the edge, result valid after it.
  logic [63:0] sx, sy;
  assign sx = {{32{mul_x[31]}}, mul_x};
  assign sy = {{32{mul_y[31]}}, mul_y};
  always @(posedge mul_clk) begin
    if (!mul_resetn)     mul_result <= 64'h0;
    else if (mul_signed) mul_result <= sx * sy;
    else                 mul_result <= {32'h0, mul_x} * {32'h0, mul_y};
  end

  task automatic step();
    @(posedge mul_clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    req_valid = 1'b1; req_op = op; req_x = x; req_y = y;
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    total++; if (mul_resetn !== 1'b0) begin bad++; $display("FAIL reset_mul_resetn got=%b exp=0", mul_resetn); end
    reset = 1'b0;
    step();
    total++; if (hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h exp=0", hi); end
    total++; if (lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h exp=0", lo); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    total++; if ({mul_x, mul_y, mul_signed} !== 65'h0) begin bad++; $display("FAIL reset_mul_ops got=%h/%h/%b exp=0", mul_x, mul_y, mul_signed); end
    total++; if (mul_resetn !== 1'b1) begin bad++; $display("FAIL reset_mul_resetn_rel got=%b exp=1", mul_resetn); end
  endtask

  task automatic test_mult();
    issue(OP_MULT, 32'hFFFF_FFFF, 32'h2);
    total++; if (req_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL mult_c1_status got ready=%b busy=%b exp 0/1", req_ready, busy); end
    total++; if (mul_x !== 32'hFFFF_FFFF || mul_y !== 32'h2 || mul_signed !== 1'b1) begin bad++; $display("FAIL mult_operands got=%h/%h/%b exp=ffffffff/2/1", mul_x, mul_y, mul_signed); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL mult_c1_done got=%b exp=0", done); end
    step();
    total++; if (req_ready !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL mult_c2 got ready=%b done=%b exp 0/0", req_ready, done); end
    step();
    total++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mult_hilo got=%h_%h exp=ffffffff_fffffffe", hi, lo); end
    total++; if (done !== 1'b1 || req_ready !== 1'b1) begin bad++; $display("FAIL mult_done got done=%b ready=%b exp 1/1", done, req_ready); end
    step();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL mult_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_multu_back_to_back();
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'h2);
    total++; if (req_ready !== 1'b0 || mul_signed !== 1'b0) begin bad++; $display("FAIL multu_c1 got ready=%b signed=%b exp 0/0", req_ready, mul_signed); end
    step();
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL multu_c2_ready got=%b exp=0", req_ready); end
    step();
    total++; if (hi !== 32'h1 || lo !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_hilo got=%h_%h exp=00000001_fffffffe", hi, lo); end
    total++; if (done !== 1'b1 || req_ready !== 1'b1) begin bad++; $display("FAIL multu_done got done=%b ready=%b exp 1/1", done, req_ready); end
    issue(OP_MULT, 32'hFFFF_FFFD, 32'h5);
    total++; if (done !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL b2b_c1 got done=%b busy=%b exp 0/1", done, busy); end
    step();
    step();
    total++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1 || done !== 1'b1) begin bad++; $display("FAIL b2b_result got=%h_%h done=%b exp=ffffffff_fffffff1 1", hi, lo, done); end
  endtask

  task automatic test_mt_with_accept();
    mthi_we = 1'b1; mt_data = 32'h55;
    issue(OP_MULT, 32'h2, 32'h3);
    mthi_we = 1'b0;
    total++; if (hi !== 32'h55) begin bad++; $display("FAIL mt_accept_hi got=%h exp=55", hi); end
    step();
    step();
    total++; if (hi !== 32'h0 || lo !== 32'h6 || done !== 1'b1) begin bad++; $display("FAIL mt_accept_result got=%h_%h done=%b exp=0_6 1", hi, lo, done); end
  endtask

  task automatic test_mt_busy();
    mthi_we = 1'b1; mt_data = 32'h1234;
    step();
    mthi_we = 1'b0;
    total++; if (hi !== 32'h1234) begin bad++; $display("FAIL mthi_idle got=%h exp=1234", hi); end
    issue(OP_MULTU, 32'h2, 32'h2);
    mthi_we = 1'b1; mtlo_we = 1'b1; mt_data = 32'hDEAD;
    step();
    mthi_we = 1'b0; mtlo_we = 1'b0;
    total++; if (hi !== 32'h1234 || lo !== 32'h6) begin bad++; $display("FAIL mt_busy_ignored got=%h_%h exp=1234_6", hi, lo); end
    step();
    total++; if (hi !== 32'h0 || lo !== 32'h4 || done !== 1'b1) begin bad++; $display("FAIL mt_busy_result got=%h_%h done=%b exp=0_4 1", hi, lo, done); end
  endtask

  task automatic test_flush();
    mthi_we = 1'b1; mtlo_we = 1'b1; mt_data = 32'h7;
    step();
    mthi_we = 1'b0; mtlo_we = 1'b0;
    total++; if (hi !== 32'h7 || lo !== 32'h7) begin bad++; $display("FAIL mt_both got=%h_%h exp=7_7", hi, lo); end
    issue(OP_MULT, 32'h5, 32'h5);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    total++; if (hi !== 32'h7 || lo !== 32'h7) begin bad++; $display("FAIL flush_hilo got=%h_%h exp=7_7", hi, lo); end
    total++; if (done !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL flush_status got done=%b ready=%b busy=%b exp 0/1/0", done, req_ready, busy); end
    step();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL flush_late_done got=%b exp=0", done); end
    flush = 1'b1;
    issue(OP_MULT, 32'h1, 32'h1);
    flush = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_idle_block got busy=%b exp=0", busy); end
    step();
    step();
    total++; if (done !== 1'b0 || lo !== 32'h7) begin bad++; $display("FAIL flush_idle_nocommit got done=%b lo=%h exp 0/7", done, lo); end
  endtask

  task automatic test_reset_mid();
    issue(OP_MULT, 32'h9, 32'h9);
    reset = 1'b1;
    step();
    total++; if (hi !== 32'h0 || lo !== 32'h0) begin bad++; $display("FAIL reset_mid_hilo got=%h_%h exp=0_0", hi, lo); end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_mid_status got busy=%b done=%b exp 0/0", busy, done); end
    reset = 1'b0;
    issue(OP_MULT, 32'h6, 32'h7);
    step();
    step();
    total++; if (hi !== 32'h0 || lo !== 32'd42 || done !== 1'b1) begin bad++; $display("FAIL reset_mid_after got=%h_%h done=%b exp=0_2a 1", hi, lo, done); end
  endtask

  task automatic test_illegal();
    issue(3'b111, 32'h3, 32'h3);
    total++; if (busy !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL illegal_idle got busy=%b ready=%b exp 0/1", busy, req_ready); end
    step();
    step();
    total++; if (done !== 1'b0 || hi !== 32'h0 || lo !== 32'd42) begin bad++; $display("FAIL illegal_nochange got done=%b hilo=%h_%h exp 0 0_2a", done, hi, lo); end
  endtask

`ifdef MUL_ACCUM_EN
  task automatic test_accum();
    mthi_we = 1'b1; mt_data = 32'h0;
    step();
    mthi_we = 1'b0; mtlo_we = 1'b1; mt_data = 32'd10;
    step();
    mtlo_we = 1'b0;
    issue(OP_MADD, 32'h3, 32'h4);
    step();
    step();
    total++; if (busy !== 1'b1 || done !== 1'b0 || lo !== 32'd10) begin bad++; $display("FAIL madd_acc_cycle got busy=%b done=%b lo=%h exp 1/0/a", busy, done, lo); end
    step();
    total++; if (hi !== 32'h0 || lo !== 32'd22 || done !== 1'b1) begin bad++; $display("FAIL madd_result got=%h_%h done=%b exp=0_16 1", hi, lo, done); end
    issue(OP_MSUBU, 32'hFFFF_FFFF, 32'h1);
    step();
    step();
    step();
    total++; if (hi !== 32'hFFFF_FFFF || lo !== 32'h17 || done !== 1'b1) begin bad++; $display("FAIL msubu_result got=%h_%h done=%b exp=ffffffff_17 1", hi, lo, done); end
    mthi_we = 1'b1; mtlo_we = 1'b1; mt_data = 32'd100;
    issue(OP_MADD, 32'h2, 32'h3);
    mthi_we = 1'b0; mtlo_we = 1'b0;
    step();
    step();
    step();
    total++; if (hi !== 32'd100 || lo !== 32'd106) begin bad++; $display("FAIL madd_after_mt got=%h_%h exp=64_6a", hi, lo); end
    issue(OP_MSUB, 32'hFFFF_FFFF, 32'h1);
    step();
    step();
    step();
    total++; if (hi !== 32'd100 || lo !== 32'd107) begin bad++; $display("FAIL msub_signed got=%h_%h exp=64_6b", hi, lo); end
    issue(OP_MADD, 32'h1, 32'h1);
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    total++; if (lo !== 32'd107 || done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL acc_flush got lo=%h done=%b busy=%b exp 6b/0/0", lo, done, busy); end
  endtask
`else
  task automatic test_accum();
    issue(OP_MADD, 32'h3, 32'h4);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL madd_disabled_idle got busy=%b exp=0", busy); end
    step();
    step();
    step();
    total++; if (done !== 1'b0 || hi !== 32'h0 || lo !== 32'd42) begin bad++; $display("FAIL madd_disabled_nochange got done=%b hilo=%h_%h exp 0 0_2a", done, hi, lo); end
  endtask
`endif

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = 3'b0; req_x = 32'h0; req_y = 32'h0;
    flush = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0; mt_data = 32'h0;
    test_reset();
    test_mult();
    test_multu_back_to_back();
    test_mt_with_accept();
    test_mt_busy();
    test_flush();
    test_reset_mid();
    test_illegal();
    test_accum();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
